vga_timing_gen: RTL
===================

Name: vga_timing_gen

Overview:
- Generates 640x480 @ 60 Hz raster timing from the 25 MHz pixel clock.
- Directly upstream of the pixel feeder; drives its disp_active, line_end and frame_end inputs.
- Drives HSYNC/VSYNC to the pad ring, delayed by a configurable number of cycles so they stay aligned with the pixel stream.
- All outputs are registered and glitch-free, because the downstream stage uses line_end and frame_end as edge triggers.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch
- H_SYNC, 96, horizontal sync width
- H_BP, 48, horizontal back porch
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch
- V_SYNC, 2, vertical sync width
- V_BP, 33, vertical back porch
- SYNC_NEG, 1, 1 = active-low sync pulses
- SYNC_DLY, 1, extra cycles of delay on hsync/vsync, range 0..7

Ports:
- clk_25  in  1  pixel clock, 25 MHz
- rst_n  in  1  reset, asynchronous, active-low
- hsync  out  1  horizontal sync to pad
- vsync  out  1  vertical sync to pad
- disp_active  out  1  high while the presented position is visible
- line_end  out  1  one-cycle pulse at the end of each visible line
- frame_end  out  1  one-cycle pulse at the end of the visible frame
- frame_cnt  out  8  frame counter, wraps 255 -> 0

Behaviour:
- Counters:
  - h_cnt runs 0..H_TOTAL-1, where H_TOTAL = 800.
  - v_cnt runs 0..V_TOTAL-1, where V_TOTAL = 525.
  - v_cnt advances only when h_cnt wraps; at (799, 524) both wrap to 0.
  - Counter widths are 10 bits, derived with $clog2 of the totals.
- Output timing:
  - Every output is a register loaded from a combinational decode of the current counters.
  - The output seen after edge k therefore describes position k-1: fixed 1-cycle latency.
- Decodes:
  - disp_active = (h_cnt < H_ACTIVE) && (v_cnt < V_ACTIVE).
  - line_end = (h_cnt == H_ACTIVE) && (v_cnt < V_ACTIVE). Exactly 480 pulses per frame, each 1 cycle wide, first blank pixel of the line.
  - frame_end = (h_cnt == 0) && (v_cnt == V_ACTIVE). Exactly 1 pulse per frame, 1 cycle wide; it never coincides with line_end.
  - hs_raw is asserted for H_ACTIVE+H_FP <= h_cnt < H_ACTIVE+H_FP+H_SYNC, i.e. 656..751.
  - vs_raw is asserted for V_ACTIVE+V_FP <= v_cnt < V_ACTIVE+V_FP+V_SYNC, i.e. 490..491.
  - When SYNC_NEG=1, asserted level = 0.
- Sync delay:
  - hs_raw and vs_raw pass through a SYNC_DLY-stage shift register after the output register.
  - Total sync latency = 1 + SYNC_DLY cycles.
- frame_cnt increments in the same cycle frame_end is registered high.
- Reset (asynchronous):
  - Counters = 0, disp_active/line_end/frame_end = 0, frame_cnt = 0.
  - hsync/vsync and every shift-register stage hold the deasserted level (1 when SYNC_NEG=1).
  - First edge after release: counters go to 1/0 and disp_active becomes 1, describing position (0,0).
- Reset mid-frame: everything returns to the reset values immediately, with no partial pulses. The new frame starts at (0,0) with full timing.
- No other inputs exist; there is no stall and no blanking override.

Decomposition:
- Package vga_pkg:
  - Timing constants (H_*/V_* defaults, H_TOTAL, V_TOTAL).
  - Widths HCNT_W = 10, VCNT_W = 10.
  - typedef logic [HCNT_W-1:0] hcnt_t and logic [VCNT_W-1:0] vcnt_t.
- One sub-module, sync_delay:
  - A parameterised DEPTH-stage shift register with reset-to-constant value.
  - Instantiated twice, once for hsync and once for vsync.
  - DEPTH = 0 passes the input straight through.
- The rest is inline.

Test Plan:
1. Reset, then release at t0 (cycle counting starts at 1 on the first edge after release). Required: disp_active = 1 from cycle 1 to cycle 640 and 0 at cycle 641. hsync = 1 (SYNC_NEG=1, SYNC_DLY=1) until it goes 0 at cycle 658 and returns to 1 at cycle 754.
2. Run two full frames, counting cycles between frame_end pulses. Required: exactly 420000. Also exactly 480 line_end pulses per frame, each exactly 800 cycles apart, and no line_end during v_cnt 480..524.
3. Check the vsync low window in cycles. Required: vsync = 0 for exactly 1600 cycles per frame. It starts at line 490 h=0, plus 2 cycles of latency.
4. Set SYNC_DLY = 0 and SYNC_DLY = 3. Required: the hsync falling edge lands at cycle 657 and cycle 660 respectively. disp_active timing is unchanged.
5. Assert rst_n low mid-line at h=300, v=200 for 3 cycles. Required: all outputs hold their reset values, and no line_end or frame_end glitch appears. After release, the case 1 timing repeats exactly and frame_cnt = 0.
6. Run 256 frames. Required: frame_cnt steps by 1 on each frame_end and wraps 255 -> 0 on the 256th pulse.

Source files
------------

// File: rtl/vga_pkg.sv
// Shared timing constants and counter types for the 640x480 @ 60 Hz raster
// generator. The *_DEF constants are the standard VGA timing and serve as the
// parameter defaults of vga_timing_gen.
package vga_pkg;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;

  localparam int H_TOTAL = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int V_TOTAL = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int HCNT_W = $clog2(H_TOTAL);
  localparam int VCNT_W = $clog2(V_TOTAL);
  localparam int FCNT_W = 8;

  typedef logic [HCNT_W-1:0] hcnt_t;
  typedef logic [VCNT_W-1:0] vcnt_t;

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the timing generator to the pixel feeder / pads.
//   hsync, vsync  : sync pulses to the pad ring (already latency-aligned)
//   disp_active   : presented position is visible
//   line_end      : one-cycle pulse on the first blank pixel of a visible line
//   frame_end     : one-cycle pulse on the first pixel of the first blank line
//   frame_cnt     : frame counter, wraps 255 -> 0
// master = timing generator, slave = consumer.
interface vga_timing_gen_if;
  import vga_pkg::*;

  logic              hsync;
  logic              vsync;
  logic              disp_active;
  logic              line_end;
  logic              frame_end;
  logic [FCNT_W-1:0] frame_cnt;

  modport master (
    output hsync, vsync, disp_active, line_end, frame_end, frame_cnt
  );

  modport slave (
    input  hsync, vsync, disp_active, line_end, frame_end, frame_cnt
  );

endinterface

// File: rtl/vga_timing_gen_sync_delay.sv
// sync_delay: DEPTH-stage shift register whose stages all reset to RST_VAL.
// DEPTH = 0 is a straight wire.
//   clk   : clock
//   rst_n : asynchronous active-low reset
//   din   : input bit
//   dout  : din delayed by DEPTH cycles
module sync_delay #(
  parameter int DEPTH   = 1,
  parameter bit RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  if (DEPTH == 0) begin : g_wire
    logic dly_unused;
    assign dly_unused = ^{clk, rst_n};
    assign dout       = din;
  end else begin : g_sr
    logic [DEPTH-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        sr <= {DEPTH{RST_VAL}};
      end else begin
        sr[0] <= din;
        for (int i = 1; i < DEPTH; i++) begin
          sr[i] <= sr[i-1];
        end
      end
    end

    assign dout = sr[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: raster timing generator (640x480 @ 60 Hz by default).
// A horizontal/vertical counter pair walks the raster; every output is a
// register loaded from a decode of the current counters, so outputs after
// edge k describe position k-1. hsync/vsync get SYNC_DLY further stages.
//   clk_25 : 25 MHz pixel clock
//   rst_n  : asynchronous active-low reset
//   vid    : timing outputs (vga_timing_gen_if master)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter bit SYNC_NEG = 1'b1,
  parameter int SYNC_DLY = 1
) (
  input  logic             clk_25,
  input  logic             rst_n,
  vga_timing_gen_if.master vid
);

  localparam int HTOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int VTOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam hcnt_t H_LAST = hcnt_t'(HTOT - 1);
  localparam hcnt_t H_VIS  = hcnt_t'(H_ACTIVE);
  localparam hcnt_t HS_BEG = hcnt_t'(H_ACTIVE + H_FP);
  localparam hcnt_t HS_END = hcnt_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam vcnt_t V_LAST = vcnt_t'(VTOT - 1);
  localparam vcnt_t V_VIS  = vcnt_t'(V_ACTIVE);
  localparam vcnt_t VS_BEG = vcnt_t'(V_ACTIVE + V_FP);
  localparam vcnt_t VS_END = vcnt_t'(V_ACTIVE + V_FP + V_SYNC);

  hcnt_t h_cnt;
  vcnt_t v_cnt;

  logic disp_p0, le_p0, fe_p0, hs_p0, vs_p0;
  logic disp_p1, le_p1, fe_p1, hs_p1, vs_p1;
  logic [FCNT_W-1:0] fcnt_p1;

  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  // ---- stage p0: combinational decode of the current position ----
  always_comb begin
    disp_p0 = (h_cnt < H_VIS) && (v_cnt < V_VIS);
    le_p0   = (h_cnt == H_VIS) && (v_cnt < V_VIS);
    fe_p0   = (h_cnt == '0) && (v_cnt == V_VIS);
    hs_p0   = (h_cnt >= HS_BEG) && (h_cnt < HS_END);
    vs_p0   = (v_cnt >= VS_BEG) && (v_cnt < VS_END);
  end

  // ---- stage p1: output registers (glitch-free pulses for edge triggers) ----
  // Sync is stored at pad polarity so the reset value is the idle level.
  always_ff @(posedge clk_25 or negedge rst_n) begin
    if (!rst_n) begin
      disp_p1 <= 1'b0;
      le_p1   <= 1'b0;
      fe_p1   <= 1'b0;
      hs_p1   <= SYNC_NEG;
      vs_p1   <= SYNC_NEG;
      fcnt_p1 <= '0;
    end else begin
      disp_p1 <= disp_p0;
      le_p1   <= le_p0;
      fe_p1   <= fe_p0;
      hs_p1   <= hs_p0 ^ SYNC_NEG;
      vs_p1   <= vs_p0 ^ SYNC_NEG;
      if (fe_p0) begin
        fcnt_p1 <= fcnt_p1 + 1'b1;
      end
    end
  end

  // ---- stage p2..: sync alignment delay towards the pads ----
  sync_delay #(.DEPTH(SYNC_DLY), .RST_VAL(SYNC_NEG)) u_hs_dly (
    .clk   (clk_25),
    .rst_n (rst_n),
    .din   (hs_p1),
    .dout  (vid.hsync)
  );

  sync_delay #(.DEPTH(SYNC_DLY), .RST_VAL(SYNC_NEG)) u_vs_dly (
    .clk   (clk_25),
    .rst_n (rst_n),
    .din   (vs_p1),
    .dout  (vid.vsync)
  );

  assign vid.disp_active = disp_p1;
  assign vid.line_end    = le_p1;
  assign vid.frame_end   = fe_p1;
  assign vid.frame_cnt   = fcnt_p1;

endmodule
